// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and stream framing constants.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects 4 stream bytes MSB-first into one 32-bit word.
// word_valid_o is combinational and fires together with the byte that completes the word.
module byte_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream, holding the core in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output loader_state_e     dbg_state
);

  // Handshake: a byte moves on any clk edge where in_valid && in_ready; in_ready is registered,
  // the producer may hold or drop in_valid freely and only transferred bytes are consumed.
  loader_state_e     state_q;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;
  logic [7:0]        hdr_hi_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] idx_q;
  logic              last_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        xfer;
  logic        start_ok;
  logic        pack_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] count_d;
  logic        count_bad;

  assign xfer       = in_valid && in_ready_q;
  assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
  assign pack_valid = xfer && (state_q == ST_DATA);
  assign count_d    = {hdr_hi_q, in_byte};
  assign count_bad  = (count_d == 16'd0) || (int'(count_d) > IMEM_DEPTH);

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_ok),
    .byte_valid_i (pack_valid),
    .byte_i       (in_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hdr_hi_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer && (state_q == ST_HDR_HI || state_q == ST_HDR_LO || state_q == ST_DATA))
        csum_q <= csum_q ^ in_byte;
`endif
      // Word completion; the final word closes the input for its write cycle.
      if (word_valid) begin
        imem_we_q <= 1'b1;
        wdata_q   <= word;
        waddr_q   <= idx_q;
        idx_q     <= idx_q + 1'b1;
        if (16'(idx_q) + 16'd1 == count_q) begin
          last_q     <= 1'b1;
          in_ready_q <= 1'b0;
        end
      end
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_ok) begin
            state_q     <= ST_HDR_HI;
            in_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            idx_q       <= '0;
            last_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
          end
        end
        ST_HDR_HI: begin
          if (xfer) begin
            hdr_hi_q <= in_byte;
            state_q  <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (xfer) begin
            count_q <= count_d;
            if (count_bad) begin
              state_q    <= ST_ERR;
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (last_q) begin
            last_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= ST_CHK;
            in_ready_q <= 1'b1;
`else
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_byte == csum_q) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expectations follow the checksum build when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  import mips_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          imem_we;
  logic [7:0]    imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  loader_state_e dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0;
  int xfer_cnt = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  stream [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'h00, 8'h07};

  imem_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe is matched against the expected queue
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(imem_waddr), 32'hffff_ffff);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("we_addr", 32'(imem_waddr), 32'(e[39:32]));
        check("we_data", imem_wdata, e[31:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) xfer_cnt++;
  end

  // drivers (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic send_words(input int gap);
    for (int i = 0; i < 10; i++) begin
      send_byte(stream[i]);
      if (i != 9) repeat (gap) @(negedge clk);
    end
    check("last_we", 32'(imem_we), 32'd1);
    check("last_ready", 32'(in_ready), 32'd0);
    check("last_done", 32'(done), 32'd0);
  endtask

  task automatic load_stream(input int gap);
    int x0;
    x0 = xfer_cnt;
    exp_q.push_back({8'h00, 32'h2008_0005});
    exp_q.push_back({8'h01, 32'h2129_0007});
    do_start();
    send_words(gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("chk_ready", 32'(in_ready), 32'd1);
    check("chk_done", 32'(done), 32'd0);
    send_byte(8'h20);
    check("load_bytes", 32'(xfer_cnt - x0), 32'd11);
`else
    @(negedge clk);
    check("load_bytes", 32'(xfer_cnt - x0), 32'd10);
`endif
    check("done", 32'(done), 32'd1);
    check("done_cpu_reset", 32'(cpu_reset), 32'd0);
    check("done_ready", 32'(in_ready), 32'd0);
    check("done_error", 32'(error), 32'd0);
    check("done_state", 32'(dbg_state), 32'(ST_DONE));
  endtask

  task automatic hdr_err(input logic [7:0] hi, input logic [7:0] lo);
    int w0;
    w0 = wr_cnt;
    do_start();
    send_byte(hi);
    send_byte(lo);
    check("hdr_error", 32'(error), 32'd1);
    check("hdr_ready", 32'(in_ready), 32'd0);
    check("hdr_cpu_reset", 32'(cpu_reset), 32'd1);
    check("hdr_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("hdr_no_we", 32'(wr_cnt - w0), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int x0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);

    // back-to-back load
    load_stream(0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // bad checksum keeps the core in reset
    exp_q.push_back({8'h00, 32'h2008_0005});
    exp_q.push_back({8'h01, 32'h2129_0007});
    do_start();
    send_words(0);
    @(negedge clk);
    send_byte(8'h21);
    check("bad_csum_error", 32'(error), 32'd1);
    check("bad_csum_cpu_reset", 32'(cpu_reset), 32'd1);
    check("bad_csum_done", 32'(done), 32'd0);
    load_stream(0);
`endif

    // trailing byte after DONE is refused
    x0 = xfer_cnt;
    in_valid = 1'b1;
    in_byte  = 8'h20;
    repeat (3) begin
      @(negedge clk);
      check("trail_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("trail_bytes", 32'(xfer_cnt - x0), 32'd0);
    check("trail_done", 32'(done), 32'd1);

    // header faults
    hdr_err(8'h00, 8'h00);
    hdr_err(8'h01, 8'h01);

    // gapped stream: in_valid 1,0,0,1,...
    load_stream(2);

    // reset mid-load, then a full reload from address 0
    exp_q.push_back({8'h00, 32'h2008_0005});
    do_start();
    for (int i = 0; i < 6; i++) send_byte(stream[i]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midrst");
    load_stream(0);

    // reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("rst_start_ready", 32'(in_ready), 32'd0);
    check("rst_start_cpu_reset", 32'(cpu_reset), 32'd1);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
